fifo_ptr_ctrl: RTL and testbench
================================

// Module: fifo_ptr_ctrl
// PURPOSE
//  Read/write pointer controller for the FIFO. Owns both pointers (address + wrap bit),
//  drives the SIZE-bit addresses into the Empty comparator and RAM, and consumes its
//  e_flag (address equality) to derive final empty/full.
//  Also produces accept strobes, an occupancy count, almost_full and sticky error flags.
// PARAMETERS
//  SIZE       4    address width; FIFO depth = 2**SIZE entries
//  AF_LEVEL  12    almost_full asserts when count >= AF_LEVEL (legal range 1..2**SIZE)
// PORTS
//  clk        in   1       single clock, rising edge
//  rst_n      in   1       asynchronous, active-low reset
//  wr_req     in   1       producer requests a write this cycle
//  rd_req     in   1       consumer requests a read this cycle
//  err_clr    in   1       synchronous clear of sticky error flags
//  e_flag     in   1       from Empty comparator: 1 when r_pointer == w_pointer
//  w_pointer  out  SIZE    write address (to RAM and Empty)
//  r_pointer  out  SIZE    read address (to RAM and Empty)
//  wr_en      out  1       write accepted this cycle (RAM write enable)
//  rd_en      out  1       read accepted this cycle
//  empty      out  1       FIFO empty
//  full       out  1       FIFO full
//  almost_full out 1       count >= AF_LEVEL
//  count      out  SIZE+1  occupancy, 0..2**SIZE
//  ovf_err    out  1       sticky: write requested while refused
//  udf_err    out  1       sticky: read requested while refused
// BEHAVIOUR
//  - State: w_wrap/w_addr, r_wrap/r_addr, count, ovf_err, udf_err; all registered.
//  - Reset (async on rst_n low, released synchronously): all pointers, count, errors = 0.
//    Resulting outputs: empty=1, full=0, almost_full=0, wr_en=0, rd_en=0.
//  - empty = e_flag & (w_wrap == r_wrap); full = e_flag & (w_wrap != r_wrap).
//    Combinational from registered state; same cycle as pointer update becomes visible.
//  - rd_en = rd_req & ~empty. Empty FIFO refuses reads even with a simultaneous write.
//    No fall-through.
//  - wr_en = wr_req & (~full | rd_en). When full, a write is accepted only with an
//    accepted read in the same cycle.
//  - On each edge: wr_en advances w_addr by 1; rd_en advances r_addr by 1.
//    An address step from 2**SIZE-1 to 0 toggles the matching wrap bit.
//  - count: +1 on wr_en only; -1 on rd_en only; unchanged on both or neither.
//    Never leaves 0..2**SIZE.
//  - count and flag consistency, checked every cycle:
//    count == {w_wrap,w_addr} - {r_wrap,r_addr} (mod 2**(SIZE+1));
//    empty <=> count == 0; full <=> count == 2**SIZE.
//  - ovf_err set on (wr_req & ~wr_en); udf_err set on (rd_req & ~rd_en).
//    Both hold until err_clr. err_clr has priority over a same-cycle set.
//  - Reset mid-operation: pointers return to 0 immediately; in-flight requests are
//    dropped; no strobes while rst_n is low.
// STRUCTURE
//  - fifo_pkg holds:
//    - constants DEPTH = 2**SIZE and PTR_W = SIZE+1
//    - typedef struct packed {logic wrap; logic [SIZE-1:0] addr;} fifo_ptr_t
//    - function ptr_inc(fifo_ptr_t) returning fifo_ptr_t
//  - One sub-module, fifo_ptr_cnt (clk, rst_n, inc, ptr out), instanced twice:
//    once for the write pointer, once for the read pointer.
//  - The Empty comparator stays a separate instance at the FIFO top; e_flag is wired back in.
// TESTING
//  (SIZE=4, AF_LEVEL=12; bench instances Empty alongside the DUT)
//  1 Reset, then idle: empty=1, full=0, count=0, both pointers 0.
//    rd_req=1 -> rd_en=0, udf_err=1 next cycle.
//  2 16 back-to-back writes from empty:
//    - almost_full rises after the 12th write (count=12).
//    - full=1 and count=16 after the 16th; w_pointer=0 and w_wrap=1.
//    - 17th wr_req -> wr_en=0, ovf_err=1.
//  3 Full, wr_req=rd_req=1 same cycle -> wr_en=1, rd_en=1; count stays 16, full stays 1.
//    Empty, wr_req=rd_req=1 -> wr_en=1, rd_en=0, count=1.
//  4 Drain 16 after fill -> r_pointer wraps to 0 and empty=1 with count=0.
//    Repeat fill/drain 3 times; count/pointer invariant holds every cycle.
//  5 err_clr=1 with ovf_err set and an offending wr_req in the same cycle -> ovf_err=0.
//  6 Assert rst_n=0 mid-burst with count=7 -> count=0, empty=1 without waiting for a clock edge.
//    wr_en=rd_en=0 until release.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared constants, pointer type and pointer-increment helper for the FIFO
// pointer controller and its companions.
package fifo_pkg;

  localparam int SIZE  = 4;
  localparam int DEPTH = 2**SIZE;
  localparam int PTR_W = SIZE + 1;

  typedef struct packed {
    logic            wrap;
    logic [SIZE-1:0] addr;
  } fifo_ptr_t;

  // The wrap bit flips exactly when the address rolls over from the last entry.
  function automatic fifo_ptr_t ptr_inc(input fifo_ptr_t p);
    fifo_ptr_t n;
    if (p.addr == SIZE'(DEPTH - 1)) begin
      n.addr = {SIZE{1'b0}};
      n.wrap = ~p.wrap;
    end else begin
      n.addr = p.addr + SIZE'(1);
      n.wrap = p.wrap;
    end
    return n;
  endfunction

endpackage

// File: rtl/fifo_empty.sv
// Empty comparator: flags address equality of the read and write pointers.
// Wrap bits are resolved by the pointer controller, not here.
module fifo_empty
  import fifo_pkg::*;
(
  input  logic [SIZE-1:0] w_pointer,
  input  logic [SIZE-1:0] r_pointer,
  output logic            e_flag
);

  assign e_flag = (w_pointer == r_pointer);

endmodule

// File: rtl/fifo_ptr_cnt.sv
// One FIFO pointer (address + wrap bit); advances by one entry on inc.
module fifo_ptr_cnt
  import fifo_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      inc,
  output fifo_ptr_t ptr
);

  fifo_ptr_t ptr_r;

  // Pointer register, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r <= '{wrap: 1'b0, addr: {SIZE{1'b0}}};
    end else if (inc) begin
      ptr_r <= ptr_inc(ptr_r);
    end else begin
      ptr_r <= ptr_r;
    end
  end

  assign ptr = ptr_r;

endmodule

// File: rtl/fifo_ptr_ctrl.sv
// FIFO read/write pointer controller: accept strobes, empty/full from the
// external address comparator, occupancy count and sticky error flags.
module fifo_ptr_ctrl
  import fifo_pkg::*;
#(
  parameter int AF_LEVEL = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_req,
  input  logic             rd_req,
  input  logic             err_clr,
  input  logic             e_flag,
  output logic [SIZE-1:0]  w_pointer,
  output logic [SIZE-1:0]  r_pointer,
  output logic             wr_en,
  output logic             rd_en,
  output logic             empty,
  output logic             full,
  output logic             almost_full,
  output logic [SIZE:0]    count,
  output logic             ovf_err,
  output logic             udf_err
);

  localparam logic [PTR_W-1:0] AF_THR = PTR_W'(AF_LEVEL);

  fifo_ptr_t        w_ptr_s;
  fifo_ptr_t        r_ptr_s;
  logic             empty_s;
  logic             full_s;
  logic             wr_en_s;
  logic             rd_en_s;
  logic [PTR_W-1:0] count_r;
  logic [PTR_W-1:0] count_nxt_s;
  logic             ovf_err_r;
  logic             udf_err_r;
  logic             ovf_nxt_s;
  logic             udf_nxt_s;

  fifo_ptr_cnt u_wr_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (wr_en_s),
    .ptr   (w_ptr_s)
  );

  fifo_ptr_cnt u_rd_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (rd_en_s),
    .ptr   (r_ptr_s)
  );

  // Flags and accept strobes; strobes are suppressed while reset is held.
  always_comb begin
    empty_s = e_flag & (w_ptr_s.wrap == r_ptr_s.wrap);
    full_s  = e_flag & (w_ptr_s.wrap != r_ptr_s.wrap);
    rd_en_s = rst_n & rd_req & ~empty_s;
    wr_en_s = rst_n & wr_req & (~full_s | rd_en_s);
  end

  // Next occupancy and sticky error values; err_clr wins over a new error.
  always_comb begin
    count_nxt_s = count_r;
    case ({wr_en_s, rd_en_s})
      2'b10:   count_nxt_s = count_r + PTR_W'(1);
      2'b01:   count_nxt_s = count_r - PTR_W'(1);
      default: count_nxt_s = count_r;
    endcase

    ovf_nxt_s = ovf_err_r;
    if (err_clr) begin
      ovf_nxt_s = 1'b0;
    end else if (wr_req & ~wr_en_s) begin
      ovf_nxt_s = 1'b1;
    end else begin
      ovf_nxt_s = ovf_err_r;
    end

    udf_nxt_s = udf_err_r;
    if (err_clr) begin
      udf_nxt_s = 1'b0;
    end else if (rd_req & ~rd_en_s) begin
      udf_nxt_s = 1'b1;
    end else begin
      udf_nxt_s = udf_err_r;
    end
  end

  // Occupancy and error state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r   <= {PTR_W{1'b0}};
      ovf_err_r <= 1'b0;
      udf_err_r <= 1'b0;
    end else begin
      count_r   <= count_nxt_s;
      ovf_err_r <= ovf_nxt_s;
      udf_err_r <= udf_nxt_s;
    end
  end

  assign w_pointer   = w_ptr_s.addr;
  assign r_pointer   = r_ptr_s.addr;
  assign wr_en       = wr_en_s;
  assign rd_en       = rd_en_s;
  assign empty       = empty_s;
  assign full        = full_s;
  assign almost_full = (count_r >= AF_THR);
  assign count       = count_r;
  assign ovf_err     = ovf_err_r;
  assign udf_err     = udf_err_r;

endmodule

// File: tb/tb_fifo_ptr_ctrl.sv
// Scoreboard bench for fifo_ptr_ctrl with the Empty comparator wired alongside;
// expectations come from an occupancy/index reference model.
module tb_fifo_ptr_ctrl;

  logic       clk;
  logic       rst_n;
  logic       wr_req;
  logic       rd_req;
  logic       err_clr;
  logic       e_flag;
  logic [3:0] w_pointer;
  logic [3:0] r_pointer;
  logic       wr_en;
  logic       rd_en;
  logic       empty;
  logic       full;
  logic       almost_full;
  logic [4:0] count;
  logic       ovf_err;
  logic       udf_err;

  fifo_ptr_ctrl #(.AF_LEVEL(12)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_req      (wr_req),
    .rd_req      (rd_req),
    .err_clr     (err_clr),
    .e_flag      (e_flag),
    .w_pointer   (w_pointer),
    .r_pointer   (r_pointer),
    .wr_en       (wr_en),
    .rd_en       (rd_en),
    .empty       (empty),
    .full        (full),
    .almost_full (almost_full),
    .count       (count),
    .ovf_err     (ovf_err),
    .udf_err     (udf_err)
  );

  fifo_empty u_empty (
    .w_pointer (w_pointer),
    .r_pointer (r_pointer),
    .e_flag    (e_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int wr_en;
    int rd_en;
    int empty;
    int full;
    int af;
    int count;
    int w_pointer;
    int r_pointer;
    int ovf;
    int udf;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: occupancy plus free-running entry indices modulo 2*DEPTH.
  int m_cnt, m_w, m_r, m_ovf, m_udf;

  task automatic check(input string nm, input int act, input int exp_v);
    n_cmp++;
    if (act != exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp_v, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_w = 0; m_r = 0; m_ovf = 0; m_udf = 0;
  endtask

  // Drive one cycle of stimulus, queue the expected view, advance the model.
  task automatic cycle(input logic w, input logic r, input logic c);
    exp_t e;
    int we, re;
    @(posedge clk);
    #1;
    wr_req = w; rd_req = r; err_clr = c;
    re = (r && m_cnt > 0) ? 1 : 0;
    we = (w && (m_cnt < 16 || re == 1)) ? 1 : 0;
    e.wr_en = we; e.rd_en = re;
    e.empty = (m_cnt == 0) ? 1 : 0;
    e.full  = (m_cnt == 16) ? 1 : 0;
    e.af    = (m_cnt >= 12) ? 1 : 0;
    e.count = m_cnt;
    e.w_pointer = m_w % 16;
    e.r_pointer = m_r % 16;
    e.ovf = m_ovf; e.udf = m_udf;
    sb.push_back(e);
    m_cnt = m_cnt + we - re;
    m_w = (m_w + we) % 32;
    m_r = (m_r + re) % 32;
    if (c) begin
      m_ovf = 0; m_udf = 0;
    end else begin
      if (w && we == 0) m_ovf = 1;
      if (r && re == 0) m_udf = 1;
    end
  endtask

  // Monitor: compare every presented cycle against the queued expectation.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check("wr_en", int'(wr_en), e.wr_en);
      check("rd_en", int'(rd_en), e.rd_en);
      check("empty", int'(empty), e.empty);
      check("full", int'(full), e.full);
      check("almost_full", int'(almost_full), e.af);
      check("count", int'(count), e.count);
      check("w_pointer", int'(w_pointer), e.w_pointer);
      check("r_pointer", int'(r_pointer), e.r_pointer);
      check("ovf_err", int'(ovf_err), e.ovf);
      check("udf_err", int'(udf_err), e.udf);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int bias;
    rst_n = 1'b0; wr_req = 1'b0; rd_req = 1'b0; err_clr = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Reset state, then read of an empty FIFO.
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1);

    // Fill to full, overflow attempt, simultaneous ops while full.
    for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    // Clear while a refused write is offered.
    cycle(1'b1, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0);

    // Drain, then simultaneous ops while empty.
    for (int i = 0; i < 16; i++) cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b1);

    // Repeated fill/drain across pointer wraps.
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 16; i++) cycle(1'b0, 1'b1, 1'b0);
    end

    // Randomized traffic with alternating write/read bias.
    for (int i = 0; i < 400; i++) begin
      bias = ((i / 50) % 2 == 0) ? 75 : 30;
      cycle(logic'($urandom_range(0, 99) < bias),
            logic'($urandom_range(0, 99) >= bias),
            logic'($urandom_range(0, 19) == 0));
    end

    // Bring occupancy to 7, then reset in the middle of a burst.
    while (m_cnt > 0) cycle(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) cycle(1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b0; wr_req = 1'b1; rd_req = 1'b1; err_clr = 1'b0;
    #1;
    model_reset();
    check("rst_count", int'(count), 0);
    check("rst_empty", int'(empty), 1);
    check("rst_full", int'(full), 0);
    check("rst_wr_en", int'(wr_en), 0);
    check("rst_rd_en", int'(rd_en), 0);
    check("rst_w_pointer", int'(w_pointer), 0);
    check("rst_r_pointer", int'(r_pointer), 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_hold_wr_en", int'(wr_en), 0);
      check("rst_hold_rd_en", int'(rd_en), 0);
      check("rst_hold_count", int'(count), 0);
    end
    @(negedge clk);
    rst_n = 1'b1; wr_req = 1'b0; rd_req = 1'b0;

    for (int i = 0; i < 60; i++) begin
      cycle(logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)), 1'b0);
    end
    cycle(1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    @(posedge clk);
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
